// File: rtl/spi_master_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) master, MSB first.
// Shifts words from a valid/ready source out on spi_mosi while capturing
// spi_miso into a parallel word. Words presented at the burst point are
// chained under a single chip-select assertion.
module spi_master_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_cnt_next;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] w_tx_shift_next;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] w_rx_shift_next;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] w_rx_data_next;
    logic              r_rx_valid;
    logic              w_rx_valid_next;
    logic              r_sck;
    logic              w_sck_next;
    logic              r_mosi;
    logic              w_mosi_next;
    logic              r_cs;
    logic              w_cs_next;
    logic              r_busy;
    logic              w_busy_next;

    logic w_half_end;
    logic w_last_bit;
    logic w_burst_pt;
    logic w_hs;

    // Last clk cycle of the current SCK half-period (or of SETUP/HOLD/GAP).
    assign w_half_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    // All DATA_W rising edges of the current word have been issued.
    assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_W));
    // Final cycle of the last SCK-high phase: a new word may chain here.
    assign w_burst_pt = (r_state == S_SHIFT) && r_sck && w_half_end && w_last_bit;

    assign tx_ready = (r_state == S_IDLE) || w_burst_pt;
    assign w_hs     = tx_valid && tx_ready;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs   = r_cs;

    // Next-state and datapath decode; every register holds unless a case updates it.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_sck_next      = r_sck;
        w_mosi_next     = r_mosi;
        w_cs_next       = r_cs;
        w_busy_next     = r_busy;

        unique case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_tx_shift_next = tx_data;
                    w_mosi_next     = tx_data[DATA_W-1];
                    w_cs_next       = 1'b0;
                    w_busy_next     = 1'b1;
                    w_cnt_next      = '0;
                    w_bit_cnt_next  = '0;
                    w_state_next    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_half_end) begin
                    // First rising edge: sample MISO on the edge that raises SCK.
                    w_cnt_next      = '0;
                    w_sck_next      = 1'b1;
                    w_rx_shift_next = {r_rx_shift[DATA_W-2:0], spi_miso};
                    w_bit_cnt_next  = r_bit_cnt + BIT_W'(1);
                    w_state_next    = S_SHIFT;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (!w_half_end) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_next = '0;
                    if (!r_sck) begin
                        w_sck_next      = 1'b1;
                        w_rx_shift_next = {r_rx_shift[DATA_W-2:0], spi_miso};
                        w_bit_cnt_next  = r_bit_cnt + BIT_W'(1);
                    end else begin
                        w_sck_next = 1'b0;
                        if (w_last_bit) begin
                            // Word complete: publish the capture, then chain or close.
                            w_rx_data_next  = r_rx_shift;
                            w_rx_valid_next = 1'b1;
                            if (w_hs) begin
                                w_tx_shift_next = tx_data;
                                w_mosi_next     = tx_data[DATA_W-1];
                                w_bit_cnt_next  = '0;
                            end else begin
                                w_state_next = S_HOLD;
                            end
                        end else begin
                            w_tx_shift_next = {r_tx_shift[DATA_W-2:0], 1'b0};
                            w_mosi_next     = r_tx_shift[DATA_W-2];
                        end
                    end
                end
            end

            S_HOLD: begin
                // MOSI keeps its last bit while CS is held after the final fall.
                if (w_half_end) begin
                    w_cnt_next   = '0;
                    w_cs_next    = 1'b1;
                    w_mosi_next  = 1'b0;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (w_half_end) begin
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset (aborts any transfer).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_sck      <= w_sck_next;
            r_mosi     <= w_mosi_next;
            r_cs       <= w_cs_next;
            r_busy     <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table of single-word vectors plus
// hand-written burst, backpressure, reset-abort, CLK_DIV=1 and idle-gap cases.
module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       cs;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic [7:0] rx_data2;
    logic       rx_valid2;
    logic       busy2;
    logic       sck2;
    logic       mosi2;
    logic       cs2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_tx #(.DATA_W(8), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso),
        .spi_cs(cs)
    );

    // CLK_DIV=1 instance with MISO looped back to MOSI.
    spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .busy(busy2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(mosi2),
        .spi_cs(cs2)
    );

    // Mode-0 slave model: presents bit (7 - rises seen) while SCK is low.
    logic [7:0] slave_word = 8'h00;
    int         rcount     = 0;
    logic       prev_sck_s = 1'b0;
    initial miso = 1'b0;
    always @(negedge clk) begin
        if (cs) rcount = 0;
        else if (sck && !prev_sck_s) rcount = rcount + 1;
        prev_sck_s = sck;
        miso = slave_word[7 - (rcount % 8)];
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        chk("wait_tx_ready", tx_ready, 1);
    endtask

    task automatic run_word(input vec_t v);
        int rises = 0, rx_n = 0, rx_t = -1, cs_hi_t = -1, rdy_t = -1;
        int first_rise = -1, last_rise = -1;
        logic [7:0] mosi_w = 8'h00, rx_d = 8'h00;
        logic psck = 1'b0;
        slave_word = v.slv;
        wait_ready();
        tx_data  = v.tx;
        tx_valid = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) begin
                tx_valid = 1'b0;
                chk("cs_low_cycle1", cs, 0);
                chk("busy_cycle1", busy, 1);
            end
            if (sck && !psck) begin
                rises++;
                mosi_w = {mosi_w[6:0], mosi};
                if (rises == 1) first_rise = t;
                last_rise = t;
            end
            psck = sck;
            if (rx_valid) begin
                rx_n++;
                rx_t = t;
                rx_d = rx_data;
            end
            if (cs && cs_hi_t < 0) cs_hi_t = t;
            if (tx_ready && t > 33 && rdy_t < 0) rdy_t = t;
        end
        chk("word_rises", rises, 8);
        chk("word_mosi", mosi_w, v.tx);
        chk("word_first_rise", first_rise, 3);
        chk("word_last_rise", last_rise, 31);
        chk("word_rx_count", rx_n, 1);
        chk("word_rx_cycle", rx_t, 33);
        chk("word_rx_data", rx_d, v.exp_rx);
        chk("word_cs_high_cycle", cs_hi_t, 35);
        chk("word_ready_cycle", rdy_t, 37);
        $display("word tx=0x%02h mosi=0x%02h rx=0x%02h rx_cyc=%0d cs_hi=%0d rdy=%0d",
                 v.tx, mosi_w, rx_d, rx_t, cs_hi_t, rdy_t);
    endtask

    // Two chained words; vary=1 drops tx_valid in cycle 1 and then holds it
    // high with data changing every cycle, so only the burst-point value counts.
    task automatic run_two(input logic [7:0] first, input bit vary, input logic [7:0] exp_second);
        int hs_n = 1, rdy_cnt = 0, rdy_t = -1, rises = 0, rx_n = 0;
        int cs_glitch = 0, cs_hi_t = -1;
        int rise_t[1:16];
        int rx_t[2];
        logic [7:0] rx_d[2];
        logic [15:0] mosi_a = 16'h0000;
        logic psck = 1'b0;
        for (int i = 1; i <= 16; i++) rise_t[i] = -1;
        rx_t[0] = -1; rx_t[1] = -1; rx_d[0] = 8'h00; rx_d[1] = 8'h00;
        slave_word = 8'h96;
        wait_ready();
        tx_data  = first;
        tx_valid = 1'b1;
        for (int t = 1; t <= 90; t++) begin
            tick();
            if (hs_n == 2) tx_valid = 1'b0;
            else if (vary) begin
                tx_valid = (t >= 2);
                tx_data  = 8'((t * 37) & 255) ^ 8'h5C;
            end else begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (tx_ready && t <= 63) begin
                rdy_cnt++;
                rdy_t = t;
            end
            if (tx_ready && tx_valid && hs_n < 2) hs_n++;
            if (sck && !psck) begin
                rises++;
                if (rises <= 16) begin
                    rise_t[rises] = t;
                    mosi_a = {mosi_a[14:0], mosi};
                end
            end
            psck = sck;
            if (rx_valid) begin
                if (rx_n < 2) begin
                    rx_t[rx_n] = t;
                    rx_d[rx_n] = rx_data;
                end
                rx_n++;
            end
            if (t <= 66 && cs) cs_glitch++;
            if (t > 66 && cs && cs_hi_t < 0) cs_hi_t = t;
        end
        chk("burst_rises", rises, 16);
        chk("burst_rise_spacing", rise_t[9] - rise_t[8], 4);
        chk("burst_rise16_cycle", rise_t[16], 63);
        chk("burst_mosi", mosi_a, {first, exp_second});
        chk("burst_ready_cycles", rdy_cnt, 1);
        chk("burst_ready_cycle", rdy_t, 32);
        chk("burst_rx_count", rx_n, 2);
        chk("burst_rx0_cycle", rx_t[0], 33);
        chk("burst_rx1_cycle", rx_t[1], 65);
        chk("burst_rx0_data", rx_d[0], 8'h96);
        chk("burst_rx1_data", rx_d[1], 8'h96);
        chk("burst_cs_stays_low", cs_glitch, 0);
        chk("burst_cs_high_cycle", cs_hi_t, 67);
        $display("burst vary=%0d mosi=0x%04h rx0@%0d rx1@%0d rdy@%0d",
                 vary, mosi_a, rx_t[0], rx_t[1], rdy_t);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{tx: 8'hA5, slv: 8'h3C, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h00, slv: 8'hFF, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, slv: 8'h00, exp_rx: 8'h00};
        vecs[3] = '{tx: 8'h81, slv: 8'h7E, exp_rx: 8'h7E};
        vecs[4] = '{tx: 8'h6C, slv: 8'hA1, exp_rx: 8'hA1};

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;
        repeat (3) tick();
        chk("reset_cs", cs, 1);
        chk("reset_sck", sck, 0);
        chk("reset_mosi", mosi, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_tx_ready", tx_ready, 1);
        $display("reset cs=%0d sck=%0d busy=%0d", cs, sck, busy);

        for (int i = 0; i < 5; i++) run_word(vecs[i]);

        run_two(8'h01, 1'b0, 8'hFF);
        run_two(8'h3A, 1'b1, 8'hFC);

        // Reset after the 3rd SCK rise aborts the word with no strobe.
        begin
            int rises = 0, rx_n = 0;
            logic psck = 1'b0;
            slave_word = 8'h3C;
            wait_ready();
            tx_data = 8'hA5; tx_valid = 1'b1;
            for (int t = 1; t <= 20; t++) begin
                tick();
                if (t == 1) tx_valid = 1'b0;
                if (rx_valid) rx_n++;
                if (sck && !psck) rises++;
                psck = sck;
                if (rises == 3) break;
            end
            chk("rst_reached_rise3", rises, 3);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_cs", cs, 1);
            chk("rst_sck", sck, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rx_data_cleared", rx_data, 0);
            for (int t = 0; t < 40; t++) begin
                if (rx_valid) rx_n++;
                tick();
            end
            chk("rst_no_rx_valid", rx_n, 0);
            $display("reset-abort rises=%0d rx_strobes=%0d", rises, rx_n);
            run_word('{tx: 8'h5A, slv: 8'hC3, exp_rx: 8'hC3});
        end

        // CLK_DIV=1 loopback transfer of 0xC3.
        begin
            int rises = 0, rx_n = 0, rx_t = -1, tog_err = 0, n = 0;
            logic [7:0] rx_d = 8'h00;
            logic psck = 1'b0;
            while (!tx_ready2 && n < 100) begin tick(); n++; end
            chk("div1_ready", tx_ready2, 1);
            tx_data2 = 8'hC3; tx_valid2 = 1'b1;
            for (int t = 1; t <= 25; t++) begin
                tick();
                if (t == 1) tx_valid2 = 1'b0;
                if (sck2 && !psck) rises++;
                psck = sck2;
                if (t >= 2 && t <= 17 && sck2 != ((t % 2) == 0)) tog_err++;
                if (rx_valid2) begin
                    rx_n++; rx_t = t; rx_d = rx_data2;
                end
            end
            chk("div1_rises", rises, 8);
            chk("div1_toggle", tog_err, 0);
            chk("div1_rx_count", rx_n, 1);
            chk("div1_rx_cycle", rx_t, 17);
            chk("div1_rx_data", rx_d, 8'hC3);
            $display("div1 rx=0x%02h rx_cyc=%0d rises=%0d", rx_d, rx_t, rises);
        end

        // Two separate frames with a single idle cycle of tx_valid low between.
        begin
            int cs_hi = 0, busy_lo = 0, rx_n = 0, rx_t1 = -1;
            logic [7:0] rx_d1 = 8'h00;
            slave_word = 8'h4D;
            wait_ready();
            tx_data = 8'h11; tx_valid = 1'b1;
            for (int t = 1; t <= 80; t++) begin
                tick();
                if (t == 1) tx_valid = 1'b0;
                if (t == 38) begin
                    tx_data = 8'h22; tx_valid = 1'b1;
                end
                if (t == 39) tx_valid = 1'b0;
                if (t >= 2 && t <= 45 && cs) cs_hi++;
                if (t >= 2 && t <= 45 && !busy) busy_lo++;
                if (rx_valid) begin
                    rx_n++;
                    if (rx_n == 2) begin rx_t1 = t; rx_d1 = rx_data; end
                end
            end
            chk("gap_cs_high_cycles", cs_hi, 4);
            chk("gap_busy_low_cycles", busy_lo, 2);
            chk("gap_rx_count", rx_n, 2);
            chk("gap_rx2_cycle", rx_t1, 71);
            chk("gap_rx2_data", rx_d1, 8'h4D);
            $display("idle-gap cs_high=%0d busy_low=%0d rx2@%0d", cs_hi, busy_lo, rx_t1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
